// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Stages the winning write and exposes hazard/forwarding info from that stage.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          hazard1,
    output logic          hazard2,
    output logic [DW-1:0] fwd_data
);

    logic          r_prio;
    logic          r_we;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wd;

    logic          w_grant0;
    logic          w_grant1;
    logic          w_xfer;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;

    // A lone requester always wins; r_prio only breaks ties.
    assign w_grant0   = !freeze && req0_valid && (!req1_valid || !r_prio);
    assign w_grant1   = !freeze && req1_valid && (!req0_valid ||  r_prio);
    assign w_xfer     = w_grant0 || w_grant1;
    assign w_sel_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
        end else if (w_xfer) begin
            r_prio <= w_grant0;
            r_we   <= (w_sel_addr != '0);
            r_wa   <= w_sel_addr;
            r_wd   <= w_sel_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign rf_we    = r_we;
    assign rf_wa    = r_wa;
    assign rf_wd    = r_wd;
    assign fwd_data = r_wd;

    // Register 0 never carries a hazard since it is hardwired to zero.
    assign hazard1 = r_we && (r_wa == rd_addr1) && (rd_addr1 != '0);
    assign hazard2 = r_we && (r_wa == rd_addr2) && (rd_addr2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset/fairness sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2), .fwd_data(fwd_data)
    );

    // Register file fed by the DUT write port; register 0 is never written.
    always @(posedge clk) begin
        if (rf_we && rf_wa != 5'd0) rf_model[rf_wa] <= rf_wd;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        frz;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_h1;
        logic        e_h2;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic frz, input logic [4:0] r1, input logic [4:0] r2);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        freeze = frz; rd_addr1 = r1; rd_addr2 = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;

        //            v0 a0  d0            v1 a1  d1            frz r1 r2  rdy0 rdy1 we wa  wd            h1 h2
        vecs[0]  = '{1, 5,  32'hDEADBEEF,  0, 0,  32'h0,        0,  5, 0,  1,   0,   1, 5,  32'hDEADBEEF,  1, 0};
        vecs[1]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0,  5, 0,  0,   0,   0, 5,  32'hDEADBEEF,  0, 0};
        vecs[2]  = '{1, 1,  32'h11,        1, 2,  32'h22,       0,  0, 0,  0,   1,   1, 2,  32'h22,        0, 0};
        vecs[3]  = '{1, 1,  32'h11,        1, 3,  32'h33,       0,  0, 0,  1,   0,   1, 1,  32'h11,        0, 0};
        vecs[4]  = '{1, 4,  32'h44,        1, 3,  32'h33,       0,  0, 0,  0,   1,   1, 3,  32'h33,        0, 0};
        vecs[5]  = '{1, 4,  32'h44,        0, 0,  32'h0,        0,  0, 0,  1,   0,   1, 4,  32'h44,        0, 0};
        vecs[6]  = '{0, 0,  32'h0,         1, 0,  32'h12345678, 0,  0, 0,  0,   1,   0, 0,  32'h12345678,  0, 0};
        vecs[7]  = '{1, 7,  32'hA5A5A5A5,  0, 0,  32'h0,        0,  7, 8,  1,   0,   1, 7,  32'hA5A5A5A5,  1, 0};
        vecs[8]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0,  7, 8,  0,   0,   0, 7,  32'hA5A5A5A5,  0, 0};
        vecs[9]  = '{0, 0,  32'h0,         1, 7,  32'h1,        0,  7, 7,  0,   1,   1, 7,  32'h1,         1, 1};
        vecs[10] = '{1, 7,  32'h2,         0, 0,  32'h0,        0,  7, 7,  1,   0,   1, 7,  32'h2,         1, 1};
        vecs[11] = '{1, 8,  32'h80,        1, 9,  32'h90,       1,  7, 7,  0,   0,   0, 7,  32'h2,         0, 0};
        vecs[12] = '{1, 8,  32'h80,        1, 9,  32'h90,       1,  7, 7,  0,   0,   0, 7,  32'h2,         0, 0};
        vecs[13] = '{1, 8,  32'h80,        1, 9,  32'h90,       1,  7, 7,  0,   0,   0, 7,  32'h2,         0, 0};
        vecs[14] = '{1, 8,  32'h80,        1, 9,  32'h90,       0,  9, 0,  0,   1,   1, 9,  32'h90,        1, 0};
        vecs[15] = '{1, 8,  32'h80,        0, 0,  32'h0,        0,  0, 8,  1,   0,   1, 8,  32'h80,        0, 1};

        // Reset state, with readys evaluated while reset is held.
        drive(1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy0", req0_ready, 1);
        chk("reset_rdy1", req1_ready, 0);
        chk("reset_we", rf_we, 0);
        chk("reset_wa", rf_wa, 0);
        chk("reset_wd", rf_wd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1,
                  vecs[i].frz, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("v%0d_rdy0", i), req0_ready, vecs[i].e_rdy0);
            chk($sformatf("v%0d_rdy1", i), req1_ready, vecs[i].e_rdy1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("v%0d_wa", i), rf_wa, vecs[i].e_wa);
            chk($sformatf("v%0d_wd", i), rf_wd, vecs[i].e_wd);
            chk($sformatf("v%0d_fwd", i), fwd_data, vecs[i].e_wd);
            chk($sformatf("v%0d_h1", i), hazard1, vecs[i].e_h1);
            chk($sformatf("v%0d_h2", i), hazard2, vecs[i].e_h2);
            if (i == 1)  chk("reg5_committed", rf_model[5], 32'hDEADBEEF);
            if (i == 7)  chk("reg0_zero", rf_model[0], 32'h0);
            if (i == 11) chk("reg7_last_write", rf_model[7], 32'h2);
        end

        // Fairness straight out of reset: grants 0,1,0,1.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 1, 32'h100 + k, 1, 2, 32'h200 + k, 0, 0, 0);
            #1;
            chk($sformatf("rr%0d_rdy0", k), req0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("rr%0d_rdy1", k), req1_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_wa", k), rf_wa, (k % 2 == 0) ? 5'd1 : 5'd2);
            chk($sformatf("rr%0d_wd", k), rf_wd, (k % 2 == 0) ? 32'h100 + k : 32'h200 + k);
        end

        // Asynchronous reset kills a staged write before it commits.
        @(negedge clk);
        drive(0, 0, 0, 1, 12, 32'hCAFEF00D, 0, 12, 0);
        @(posedge clk);
        #1;
        chk("ar_staged_we", rf_we, 1);
        chk("ar_staged_h1", hazard1, 1);
        drive(1, 3, 32'h3, 1, 4, 32'h4, 0, 12, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", rf_we, 0);
        chk("ar_wa", rf_wa, 0);
        chk("ar_wd", rf_wd, 0);
        chk("ar_h1", hazard1, 0);
        chk("ar_rdy0_prio0", req0_ready, 1);
        chk("ar_rdy1_prio0", req1_ready, 0);
        @(posedge clk);
        #1;
        chk("ar_reg12_not_written", rf_model[12], 32'h0);
        chk("ar_we_held", rf_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_post_rdy0", req0_ready, 1);
        @(posedge clk);
        #1;
        chk("ar_post_wa", rf_wa, 3);
        chk("ar_post_wd", rf_wd, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two write-back sources: the ALU path (source 0) and the load/multi-cycle path (source 1). It accepts one write per cycle under a valid/ready handshake, with round-robin priority when both sources request. It registers the winning write into the register-file write port (WE/WA/WD). It also flags read-after-write hazards for the two read ports while a write is staged, and supplies the staged data for forwarding.

## Interface
Parameters:
- AW, 5, register address width (32 registers)
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  pipeline freeze; blocks all acceptance while high
- req0_valid  in  1  source 0 (ALU) has a write pending
- req0_addr  in  AW  source 0 destination register
- req0_data  in  DW  source 0 write data
- req0_ready  out  1  source 0 write accepted this cycle
- req1_valid  in  1  source 1 (load/multi-cycle) has a write pending
- req1_addr  in  AW  source 1 destination register
- req1_data  in  DW  source 1 write data
- req1_ready  out  1  source 1 write accepted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  AW  register-file write address (registered)
- rf_wd  out  DW  register-file write data (registered)
- rd_addr1, rd_addr2  in  AW  register-file read addresses currently being used
- hazard1, hazard2  out  1  staged write targets rd_addr1 / rd_addr2
- fwd_data  out  DW  forwarding value; equals rf_wd

## Operation
- Handshake:
  - A transfer on source k occurs when reqk_valid && reqk_ready.
  - A source must hold valid, addr and data stable until it is accepted; the arbiter never drops a valid request.
- Arbitration state: a one-bit pointer `prio` (0 = source 0 favoured).
  - freeze=1: req0_ready = req1_ready = 0.
  - Only one source valid: that source's ready = 1.
  - Both valid: ready goes to the source selected by `prio`; the other source gets 0.
  - After any transfer, `prio` moves to the source that did not win. With no transfer, `prio` holds.
  - The ready outputs are combinational from valid, freeze and `prio`. At most one ready is high per cycle.
- Output stage, updated on every edge:
  - On a transfer: rf_wa/rf_wd load the winner's addr/data, and rf_we = (addr != 0). Writes to register 0 are consumed but never committed.
  - No transfer (including under freeze): rf_we = 0; rf_wa/rf_wd hold their previous values.
- Hazard and forwarding:
  - hazardK = rf_we && (rf_wa == rd_addrK) && (rd_addrK != 0).
  - fwd_data = rf_wd.
  - Both are combinational from the staged registers.
- Reset (asynchronous, rst_n low): rf_we = 0, rf_wa = 0, rf_wd = 0, prio = 0. hazard1/2 = 0 as a consequence.
  - An accepted write still in the output stage when reset asserts is lost.
  - While rst_n is low, readys evaluate normally, but no state updates.

## Timing
- Acceptance to commit latency: an accept in cycle N drives rf_we/rf_wa/rf_wd during cycle N+1. The register file writes at the end of cycle N+1, and the value is readable from cycle N+2.
- Hazard window: hazardK is high only in cycle N+1. A consumer may take fwd_data in that cycle instead of stalling.
- Throughput: one write per cycle sustained, independent of which source wins.
- Fairness: with both sources continuously valid, grants alternate 0,1,0,1… Worst-case wait is 1 cycle.
- Freeze: while freeze is high, the cycle after it rises and every following frozen cycle has rf_we = 0. `prio` is unchanged across a freeze.
- Simultaneous events:
  - Both sources targeting the same address resolve in grant order; the later write wins in the register file.
  - When the same register is written on consecutive cycles, hazard reflects only the currently staged write.

## Test plan
- After reset, only req0 valid with addr=5, data=0xDEADBEEF → req0_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; reg5 reads 0xDEADBEEF one cycle later.
- Both valid continuously for 4 cycles after reset (req0 addr=1, req1 addr=2) → grants 0,1,0,1; rf_wa sequence 1,2,1,2; no request lost.
- Write to addr=0 with data=0x12345678 → ready=1, rf_we stays 0, register 0 remains 0, hazard1=0 with rd_addr1=0.
- Accept a write to addr=7, data=0xA5A5A5A5 with rd_addr1=7, rd_addr2=8 → next cycle hazard1=1, hazard2=0, fwd_data=0xA5A5A5A5; the cycle after, hazard1=0.
- freeze=1 for 3 cycles with both sources valid → both readys 0 and rf_we=0 throughout; after release, grant goes to the source favoured by `prio` before the freeze.
- rst_n pulled low asynchronously mid-cycle with rf_we=1 → rf_we/rf_wa/rf_wd go to 0 immediately without a clock edge; the staged write is not committed; after release, prio=0.
